// File: rtl/lru_stack_tracker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : lru_stack_tracker                                          |
// | Description : Per-set true-LRU ordering stacks with touch/demote updates |
// |               and a one-cycle victim query with update forwarding.       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module lru_stack_tracker #(
  parameter  int WAYS  = 4,
  parameter  int SETS  = 8,
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1,
  localparam int SET_W = (SETS > 1) ? $clog2(SETS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             upd_valid,
  input  logic             upd_op,
  input  logic [SET_W-1:0] upd_set,
  input  logic [WAY_W-1:0] upd_way,
  input  logic             qry_valid,
  input  logic [SET_W-1:0] qry_set,
  output logic             victim_valid,
  output logic [WAY_W-1:0] victim_way
);

  // Storage spans the full index range so a 1-set build still decodes a 1-bit index.
  localparam int  c_DEPTH   = 1 << SET_W;
  localparam logic c_TOUCH  = 1'b0;

  logic [WAY_W-1:0] r_stack [c_DEPTH][WAYS];
  logic             r_victim_valid;
  logic [WAY_W-1:0] r_victim_way;

  logic [WAY_W-1:0] w_old  [WAYS];
  logic [WAY_W-1:0] w_new  [WAYS];
  logic [WAYS-1:0]  w_hit;
  logic [WAYS-1:0]  w_prefix;
  logic             w_run;
  logic [WAY_W-1:0] w_qry_lru;

  always_comb begin
    w_run = 1'b0;
    for (int i = 0; i < WAYS; i++) begin
      w_old[i]    = r_stack[upd_set][i];
      w_hit[i]    = (w_old[i] == upd_way);
      w_run       = w_run | w_hit[i];
      w_prefix[i] = w_run;
    end
  end

  // w_prefix[i] is set when the updated way sits at position i or above (closer to MRU).
  always_comb begin
    for (int i = 0; i < WAYS; i++) begin
      w_new[i] = w_old[i];
    end
    if (upd_op == c_TOUCH) begin
      w_new[0] = upd_way;
      for (int i = 1; i < WAYS; i++) begin
        w_new[i] = w_prefix[i-1] ? w_old[i] : w_old[i-1];
      end
    end else begin
      for (int i = 0; i < WAYS - 1; i++) begin
        w_new[i] = w_prefix[i] ? w_old[i+1] : w_old[i];
      end
      w_new[WAYS-1] = upd_way;
    end
  end

  always_comb begin
    w_qry_lru = r_stack[qry_set][WAYS-1];
    if (upd_valid && (upd_set == qry_set)) begin
      w_qry_lru = w_new[WAYS-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < c_DEPTH; s++) begin
        for (int i = 0; i < WAYS; i++) begin
          r_stack[s][i] <= WAY_W'(i);
        end
      end
      r_victim_valid <= 1'b0;
      r_victim_way   <= '0;
    end else begin
      if (upd_valid) begin
        for (int i = 0; i < WAYS; i++) begin
          r_stack[upd_set][i] <= w_new[i];
        end
      end
      r_victim_valid <= qry_valid;
      if (qry_valid) begin
        r_victim_way <= w_qry_lru;
      end
    end
  end

  assign victim_valid = r_victim_valid;
  assign victim_way   = r_victim_way;

endmodule
`default_nettype wire

// File: tb/tb_lru_stack_tracker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_lru_stack_tracker                                       |
// | Description : Directed table, corner sequences and randomized checks of  |
// |               lru_stack_tracker against a queue-based LRU model.         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_lru_stack_tracker;

  localparam int WAYS = 4;
  localparam int SETS = 8;

  logic       clk = 1'b0;
  logic       rst, upd_valid, upd_op, qry_valid;
  logic [2:0] upd_set, qry_set;
  logic [1:0] upd_way;
  logic       victim_valid;
  logic [1:0] victim_way;

  logic       rst2, upd_valid2, upd_op2, qry_valid2;
  logic [0:0] upd_set2, qry_set2;
  logic [2:0] upd_way2;
  logic       victim_valid2;
  logic [2:0] victim_way2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lru_stack_tracker #(.WAYS(WAYS), .SETS(SETS)) dut (
    .clk(clk), .rst(rst), .upd_valid(upd_valid), .upd_op(upd_op),
    .upd_set(upd_set), .upd_way(upd_way), .qry_valid(qry_valid),
    .qry_set(qry_set), .victim_valid(victim_valid), .victim_way(victim_way)
  );

  lru_stack_tracker #(.WAYS(8), .SETS(2)) dut8 (
    .clk(clk), .rst(rst2), .upd_valid(upd_valid2), .upd_op(upd_op2),
    .upd_set(upd_set2), .upd_way(upd_way2), .qry_valid(qry_valid2),
    .qry_set(qry_set2), .victim_valid(victim_valid2), .victim_way(victim_way2)
  );

  // Reference: each set is a queue ordered MRU..LRU.
  int unsigned mdl [SETS][$];
  logic        exp_vv;
  logic [1:0]  exp_vw;

  task automatic mdl_reset();
    for (int s = 0; s < SETS; s++) begin
      mdl[s].delete();
      for (int w = 0; w < WAYS; w++) mdl[s].push_back(w);
    end
  endtask

  task automatic mdl_update(input logic op, input int s, input int w);
    int p = 0;
    for (int i = 0; i < mdl[s].size(); i++) if (mdl[s][i] == w) p = i;
    mdl[s].delete(p);
    if (op == 1'b0) mdl[s].push_front(w);
    else            mdl[s].push_back(w);
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle of requests, advance the model, and sample after the edge.
  task automatic step(input logic r, input logic uv, input logic op, input logic [2:0] us,
                      input logic [1:0] uw, input logic qv, input logic [2:0] qs);
    rst = r; upd_valid = uv; upd_op = op; upd_set = us; upd_way = uw;
    qry_valid = qv; qry_set = qs;
    if (r) begin
      mdl_reset();
      exp_vv = 1'b0;
      exp_vw = 2'd0;
    end else begin
      if (uv) mdl_update(op, int'(us), int'(uw));
      exp_vv = qv;
      if (qv) exp_vw = 2'(mdl[qs][WAYS-1]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step8(input logic r, input logic uv, input logic [0:0] us,
                       input logic [2:0] uw, input logic qv, input logic [0:0] qs);
    rst2 = r; upd_valid2 = uv; upd_op2 = 1'b0; upd_set2 = us; upd_way2 = uw;
    qry_valid2 = qv; qry_set2 = qs;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       r;
    logic       uv;
    logic       op;
    logic [2:0] us;
    logic [1:0] uw;
    logic       qv;
    logic [2:0] qs;
    logic       ev;
    logic [1:0] ew;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic uv, input logic op, input logic [2:0] us,
                              input logic [1:0] uw, input logic qv, input logic [2:0] qs,
                              input logic ev, input logic [1:0] ew);
    vec_t v;
    v.r = r; v.uv = uv; v.op = op; v.us = us; v.uw = uw;
    v.qv = qv; v.qs = qs; v.ev = ev; v.ew = ew;
    return v;
  endfunction

  vec_t tbl [22];

  initial begin
    rst = 1'b1; upd_valid = 1'b0; upd_op = 1'b0; upd_set = '0; upd_way = '0;
    qry_valid = 1'b0; qry_set = '0;
    rst2 = 1'b1; upd_valid2 = 1'b0; upd_op2 = 1'b0; upd_set2 = '0; upd_way2 = '0;
    qry_valid2 = 1'b0; qry_set2 = '0;
    exp_vv = 1'b0; exp_vw = 2'd0;
    mdl_reset();

    //            r     uv    op    set   way   qv    qset  ev    ew
    tbl[0]  = mk(1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 3'd0, 1'b0, 2'd0);
    tbl[1]  = mk(1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 1'b1, 3'd5, 1'b1, 2'd3);
    tbl[2]  = mk(1'b0, 1'b1, 1'b0, 3'd2, 2'd3, 1'b0, 3'd0, 1'b0, 2'd3);
    tbl[3]  = mk(1'b0, 1'b1, 1'b0, 3'd2, 2'd2, 1'b0, 3'd0, 1'b0, 2'd3);
    tbl[4]  = mk(1'b0, 1'b1, 1'b0, 3'd2, 2'd1, 1'b0, 3'd0, 1'b0, 2'd3);
    tbl[5]  = mk(1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 1'b1, 3'd2, 1'b1, 2'd0);
    tbl[6]  = mk(1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 1'b1, 3'd3, 1'b1, 2'd3);
    tbl[7]  = mk(1'b0, 1'b1, 1'b0, 3'd1, 2'd0, 1'b0, 3'd0, 1'b0, 2'd3);
    tbl[8]  = mk(1'b0, 1'b1, 1'b1, 3'd1, 2'd2, 1'b0, 3'd0, 1'b0, 2'd3);
    tbl[9]  = mk(1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 1'b1, 3'd1, 1'b1, 2'd2);
    tbl[10] = mk(1'b0, 1'b1, 1'b0, 3'd1, 2'd2, 1'b0, 3'd0, 1'b0, 2'd2);
    tbl[11] = mk(1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 1'b1, 3'd1, 1'b1, 2'd3);
    tbl[12] = mk(1'b0, 1'b1, 1'b0, 3'd4, 2'd3, 1'b1, 3'd4, 1'b1, 2'd2);
    tbl[13] = mk(1'b0, 1'b1, 1'b0, 3'd0, 2'd3, 1'b0, 3'd0, 1'b0, 2'd2);
    tbl[14] = mk(1'b0, 1'b1, 1'b0, 3'd6, 2'd3, 1'b0, 3'd0, 1'b0, 2'd2);
    tbl[15] = mk(1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 1'b1, 3'd0, 1'b1, 2'd2);
    tbl[16] = mk(1'b1, 1'b1, 1'b0, 3'd6, 2'd1, 1'b1, 3'd0, 1'b0, 2'd0);
    tbl[17] = mk(1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 1'b1, 3'd0, 1'b1, 2'd3);
    tbl[18] = mk(1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 1'b1, 3'd6, 1'b1, 2'd3);
    tbl[19] = mk(1'b0, 1'b1, 1'b1, 3'd6, 2'd3, 1'b1, 3'd6, 1'b1, 2'd3);
    tbl[20] = mk(1'b0, 1'b1, 1'b1, 3'd7, 2'd0, 1'b1, 3'd3, 1'b1, 2'd3);
    tbl[21] = mk(1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 1'b1, 3'd7, 1'b1, 2'd0);

    for (int i = 0; i < 22; i++) begin
      step(tbl[i].r, tbl[i].uv, tbl[i].op, tbl[i].us, tbl[i].uw, tbl[i].qv, tbl[i].qs);
      check($sformatf("vec%0d_valid", i), int'(victim_valid), int'(tbl[i].ev));
      check($sformatf("vec%0d_way", i), int'(victim_way), int'(tbl[i].ew));
    end

    // Eight-way, two-set build: touch set 1 with ways 7 down to 1.
    step8(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    check("w8_reset_valid", int'(victim_valid2), 0);
    check("w8_reset_way", int'(victim_way2), 0);
    for (int w = 7; w >= 1; w--) step8(1'b0, 1'b1, 1'b1, 3'(w), 1'b0, 1'b0);
    check("w8_idle_valid", int'(victim_valid2), 0);
    step8(1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1);
    check("w8_set1_valid", int'(victim_valid2), 1);
    check("w8_set1_way", int'(victim_way2), 0);
    step8(1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    check("w8_set0_valid", int'(victim_valid2), 1);
    check("w8_set0_way", int'(victim_way2), 7);
    step8(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    check("w8_hold_way", int'(victim_way2), 7);

    // Randomized traffic against the queue model.
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 39) == 0), 1'($urandom), 1'($urandom),
           3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
           1'($urandom), 3'($urandom_range(0, 7)));
      check($sformatf("rnd%0d_valid", n), int'(victim_valid), int'(exp_vv));
      check($sformatf("rnd%0d_way", n), int'(victim_way), int'(exp_vw));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lru_stack_tracker.md
LRU_STACK_TRACKER -- requirements
Module: lru_stack_tracker

Interface
REQ-001 The block SHALL have parameter WAYS, default 4, giving the associativity; legal values are powers of two from 2 to 16.
REQ-002 The block SHALL have parameter SETS, default 8, giving the number of sets; legal values are powers of two from 1 to 256.
REQ-003 The block SHALL use the derived widths WAY_W = max(1, clog2(WAYS)) and SET_W = max(1, clog2(SETS)).
REQ-004 Port clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 Port upd_valid, input, 1 bit: an order-update request is present this cycle.
REQ-007 Port upd_op, input, 1 bit: update type; 0 = touch (move to MRU), 1 = demote (move to LRU).
REQ-008 Port upd_set, input, SET_W bits: set index for the update.
REQ-009 Port upd_way, input, WAY_W bits: way being touched or demoted.
REQ-010 Port qry_valid, input, 1 bit: victim query request.
REQ-011 Port qry_set, input, SET_W bits: set index to query.
REQ-012 Port victim_valid, output, 1 bit: victim_way carries a query result this cycle.
REQ-013 Port victim_way, output, WAY_W bits: the LRU way of the queried set.

Function
REQ-014 Each set SHALL hold an ordered stack of WAYS entries, each WAY_W bits wide, at positions 0 (MRU) to WAYS-1 (LRU), so that every stack is always a permutation of 0..WAYS-1.
REQ-015 A touch SHALL locate the position p holding upd_way, shift positions 0..p-1 down by one, and write upd_way to position 0, all in one clock edge.
REQ-016 A touch of a way already at position 0 SHALL leave the stack unchanged.
REQ-017 A demote SHALL locate the position p holding upd_way, shift positions p+1..WAYS-1 up by one, and write upd_way to position WAYS-1.
REQ-018 A demote of a way already at position WAYS-1 SHALL leave the stack unchanged.
REQ-019 An update SHALL modify only the stack of upd_set; all other sets hold their state.
REQ-020 The block SHALL accept an update every cycle with no stall and no ready signal; back-to-back updates to the same set SHALL each see the result of the previous one.
REQ-021 A query SHALL have a latency of one cycle: qry_valid at cycle t drives victim_valid=1 and victim_way = position WAYS-1 of qry_set at cycle t+1.
REQ-022 victim_valid SHALL be 0 in any cycle that does not follow a qry_valid.
REQ-023 When an update and a query target the same set in the same cycle, the query result SHALL reflect the stack after that update (forwarding).
REQ-024 When an update and a query target different sets in the same cycle, the query result SHALL reflect the queried set's stack unchanged by that update.
REQ-025 victim_way SHALL hold its last value while victim_valid is 0.

Reset
REQ-026 When rst is high at a clock edge, every set's stack SHALL become position i = way i, for i = 0..WAYS-1, so that the LRU way is WAYS-1.
REQ-027 When rst is high at a clock edge, victim_valid SHALL become 0 and victim_way SHALL become 0.
REQ-028 rst SHALL take priority over upd_valid and qry_valid; requests in a reset cycle SHALL be discarded, with no result in the following cycle.
REQ-029 Reset SHALL complete in a single cycle, so that requests in the first cycle after rst is deasserted are serviced normally.

Verification (WAYS=4, SETS=8 unless stated)
REQ-030 The bench SHALL apply reset, then a query of set 5, and check victim_valid=1 and victim_way=3 one cycle later.
REQ-031 The bench SHALL touch set 2 with ways 3, 2, 1 on consecutive cycles, then query sets 2 and 3, and check victims 0 and 3 respectively.
REQ-032 The bench SHALL, on set 1, touch way 0 and then demote way 2, check that the victim is 2, then touch way 2 and check that the victim is 3 (stack 2,0,1,3).
REQ-033 The bench SHALL issue a touch of set 4 way 3 and a query of set 4 in the same cycle, and check victim_way=2 at the next cycle.
REQ-034 The bench SHALL, after modifying sets 0 and 6, assert rst together with upd_valid and qry_valid, and check that victim_valid=0 in the next cycle and that queries of sets 0 and 6 then return 3.
REQ-035 The bench SHALL, in a WAYS=8, SETS=2 build, touch set 1 with ways 7 down to 1, and check victim 0 for set 1 and victim 7 for set 0.
